// File: rtl/sp_pkg.sv
// Shared definitions for the serial_paralelo_param lane receiver:
// FSM state encoding and the default comma / lock-depth constants.
package sp_pkg;

  typedef enum logic [1:0] {
    SP_HUNT   = 2'd0,
    SP_ALIGN  = 2'd1,
    SP_LOCKED = 2'd2
  } sp_state_e;

  localparam logic [7:0] SP_COMMA_DEF    = 8'hBC;
  localparam int         SP_LOCK_CNT_DEF = 4;

endpackage

// File: rtl/serial_paralelo_param_if.sv
// Lane-side bundle of the serial_paralelo_param receiver.
// slave  : the receiver itself (takes the serial bit, drives word outputs).
// master : whatever feeds the lane and consumes the recovered words.
interface serial_paralelo_param_if #(
  parameter int W = 8
);
  logic         data_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         word_strobe;
  logic         IDLE_OUT;
  logic         locked;

  modport master (
    output data_in,
    input  data_out, valid_out, word_strobe, IDLE_OUT, locked
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, word_strobe, IDLE_OUT, locked
  );
endinterface

// File: rtl/sp_shift_deser.sv
// Bit-level front end: keeps the last W-1 received bits, presents the
// W-bit window ending with the current bit (nxt), and tracks the bit
// position inside a word. realign holds the position counter at zero so
// that the cycle after it drops is the first bit of a word.
module sp_shift_deser #(
  parameter int W = 8
) (
  input  logic         clk_32f,
  input  logic         reset,
  input  logic         data_in,
  input  logic         realign,
  output logic [W-1:0] nxt,
  output logic         boundary
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  // The oldest bit of the W-wide window is never looked at again once the
  // window moves on, so only W-1 history bits are stored.
  logic [W-2:0]  sr;
  logic [BW-1:0] bit_cnt;

  assign nxt      = {sr, data_in};
  assign boundary = (bit_cnt == LAST_BIT);

  // Shift in one bit per clock and step the word position, wrapping
  // W-1 -> 0 with no idle cycle between words.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= nxt[W-2:0];
      if (realign || boundary)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_paralelo_param.sv
// Parametrised serial-to-parallel lane receiver. Hunts for the comma
// symbol at any bit offset, locks after LOCK_CNT consecutive aligned
// commas, then delivers words with valid_out / word_strobe / IDLE_OUT.
// Optional build macro SP_RELOCK_EN: drop lock and re-hunt after MAX_GAP
// consecutive comma-free words. Without it LOCKED holds until reset.
module serial_paralelo_param
  import sp_pkg::*;
#(
  parameter int           W        = 8,
  parameter logic [W-1:0] COMMA    = W'(SP_COMMA_DEF),
  parameter int           LOCK_CNT = SP_LOCK_CNT_DEF,
  parameter int           MAX_GAP  = 64
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  serial_paralelo_param_if.slave bus
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  // Reject configurations the receiver cannot work with.
  if (W < 2 || COMMA == '0 || LOCK_CNT < 1 || MAX_GAP < 1) begin : g_bad_params
    $error("serial_paralelo_param: illegal parameter combination");
  end

  sp_state_e     state;
  logic [CW-1:0] comma_cnt;
  logic [W-1:0]  nxt;
  logic          boundary;
  logic          realign;
  logic          is_comma;
  logic          drop_lock;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          strobe_q;
  logic          idle_q;

  // While hunting, the word position is pinned at zero so a comma match
  // leaves the deserialiser aligned to the following word.
  assign realign  = (state == SP_HUNT);
  assign is_comma = (nxt == COMMA);

  sp_shift_deser #(.W(W)) u_deser (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (bus.data_in),
    .realign  (realign),
    .nxt      (nxt),
    .boundary (boundary)
  );

`ifdef SP_RELOCK_EN
  localparam int GW = $clog2(MAX_GAP + 1);
  logic [GW-1:0] gap_cnt;

  // The word that reaches MAX_GAP is still delivered; lock drops one edge
  // later, which is never a boundary because W is at least 2.
  assign drop_lock = (state == SP_LOCKED) && (gap_cnt == GW'(MAX_GAP));

  // Count consecutive comma-free words while locked.
  always_ff @(posedge clk_32f) begin
    if (!reset || drop_lock)
      gap_cnt <= '0;
    else if (state == SP_LOCKED && boundary)
      gap_cnt <= is_comma ? '0 : gap_cnt + 1'b1;
  end
`else
  assign drop_lock = 1'b0;
`endif

  // Alignment FSM plus the registered word outputs.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state     <= SP_HUNT;
      comma_cnt <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        SP_HUNT: begin
          if (is_comma) begin
            comma_cnt <= CW'(1);
            if (LOCK_CNT == 1) begin
              state    <= SP_LOCKED;
              strobe_q <= 1'b1;
              idle_q   <= 1'b1;
              valid_q  <= 1'b0;
            end else begin
              state <= SP_ALIGN;
            end
          end
        end
        SP_ALIGN: begin
          if (boundary) begin
            if (is_comma) begin
              if (comma_cnt != CW'(LOCK_CNT))
                comma_cnt <= comma_cnt + 1'b1;
              if (int'(comma_cnt) + 1 >= LOCK_CNT) begin
                state    <= SP_LOCKED;
                strobe_q <= 1'b1;
                idle_q   <= 1'b1;
                valid_q  <= 1'b0;
              end
            end else begin
              state     <= SP_HUNT;
              comma_cnt <= '0;
            end
          end
        end
        SP_LOCKED: begin
          if (drop_lock) begin
            state     <= SP_HUNT;
            comma_cnt <= '0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b0;
          end else if (boundary) begin
            strobe_q <= 1'b1;
            if (is_comma) begin
              valid_q <= 1'b0;
              idle_q  <= 1'b1;
            end else begin
              data_q  <= nxt;
              valid_q <= 1'b1;
              idle_q  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= SP_HUNT;
          comma_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.word_strobe = strobe_q;
  assign bus.IDLE_OUT    = idle_q;
  assign bus.locked      = (state == SP_LOCKED);

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Directed self-checking bench for serial_paralelo_param (W=8, COMMA=BC,
// LOCK_CNT=4, MAX_GAP=4). Honours SP_RELOCK_EN in the relock scenario.
module tb_serial_paralelo_param;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  serial_paralelo_param_if #(.W(8)) bus ();

  serial_paralelo_param #(
    .W(8), .COMMA(8'hBC), .LOCK_CNT(4), .MAX_GAP(4)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  // Bit clock.
  always #5 clk_32f = ~clk_32f;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  // Packs outputs as {locked, IDLE_OUT, valid_out, word_strobe, data_out}.
  function automatic logic [11:0] outs();
    return {bus.locked, bus.IDLE_OUT, bus.valid_out, bus.word_strobe, bus.data_out};
  endfunction

  // Present one bit, let the next rising edge sample it, settle 1 time unit.
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send bits w[hi] down to w[lo], MSB first.
  task automatic send_range(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_range(w, 7, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom));
      vectors++;
      if (outs() !== 12'h000) begin
        $display("[TB] FAIL reset_hold[%0d]: got %h expected %h", i, outs(), 12'h000);
        miscompares++;
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    for (int k = 0; k < 3; k++) begin
      send_word(8'hBC);
      vectors++;
      if (outs() !== 12'h000) begin
        $display("[TB] FAIL lock_prelock_bc%0d: got %h expected %h", k, outs(), 12'h000);
        miscompares++;
      end
    end
    send_range(8'hBC, 7, 1);
    vectors++;
    if (outs() !== 12'h000) begin
      $display("[TB] FAIL lock_edge31: got %h expected %h", outs(), 12'h000);
      miscompares++;
    end
    send_bit(1'b0);
    vectors++;
    if (outs() !== {4'b1101, 8'h00}) begin
      $display("[TB] FAIL lock_edge32: got %h expected %h", outs(), {4'b1101, 8'h00});
      miscompares++;
    end
    send_bit(1'b1);
    vectors++;
    if (outs() !== {4'b1100, 8'h00}) begin
      $display("[TB] FAIL lock_strobe_drop: got %h expected %h", outs(), {4'b1100, 8'h00});
      miscompares++;
    end
    send_range(8'hFF, 6, 0);
    vectors++;
    if (outs() !== {4'b1011, 8'hFF}) begin
      $display("[TB] FAIL lock_word_ff: got %h expected %h", outs(), {4'b1011, 8'hFF});
      miscompares++;
    end
    send_range(8'hEE, 7, 4);
    vectors++;
    if (outs() !== {4'b1010, 8'hFF}) begin
      $display("[TB] FAIL lock_hold_ff: got %h expected %h", outs(), {4'b1010, 8'hFF});
      miscompares++;
    end
    send_range(8'hEE, 3, 0);
    vectors++;
    if (outs() !== {4'b1011, 8'hEE}) begin
      $display("[TB] FAIL lock_word_ee: got %h expected %h", outs(), {4'b1011, 8'hEE});
      miscompares++;
    end
  endtask

  task automatic test_align_reject();
    do_reset();
    for (int k = 0; k < 3; k++) send_word(8'hBC);
    send_word(8'h55);
    vectors++;
    if (outs() !== 12'h000) begin
      $display("[TB] FAIL reject_after_55: got %h expected %h", outs(), 12'h000);
      miscompares++;
    end
    for (int k = 0; k < 3; k++) begin
      send_word(8'hBC);
      vectors++;
      if (outs() !== 12'h000) begin
        $display("[TB] FAIL reject_rehunt_bc%0d: got %h expected %h", k, outs(), 12'h000);
        miscompares++;
      end
    end
    send_word(8'hBC);
    vectors++;
    if (outs() !== {4'b1101, 8'h00}) begin
      $display("[TB] FAIL reject_relock: got %h expected %h", outs(), {4'b1101, 8'h00});
      miscompares++;
    end
  endtask

  task automatic test_idle_hold();
    send_word(8'hDD);
    vectors++;
    if (outs() !== {4'b1011, 8'hDD}) begin
      $display("[TB] FAIL idle_word_dd: got %h expected %h", outs(), {4'b1011, 8'hDD});
      miscompares++;
    end
    send_range(8'hBC, 7, 4);
    vectors++;
    if (outs() !== {4'b1010, 8'hDD}) begin
      $display("[TB] FAIL idle_mid_bc: got %h expected %h", outs(), {4'b1010, 8'hDD});
      miscompares++;
    end
    send_range(8'hBC, 3, 0);
    vectors++;
    if (outs() !== {4'b1101, 8'hDD}) begin
      $display("[TB] FAIL idle_comma: got %h expected %h", outs(), {4'b1101, 8'hDD});
      miscompares++;
    end
    send_range(8'hCC, 7, 5);
    vectors++;
    if (outs() !== {4'b1100, 8'hDD}) begin
      $display("[TB] FAIL idle_hold_comma: got %h expected %h", outs(), {4'b1100, 8'hDD});
      miscompares++;
    end
    send_range(8'hCC, 4, 0);
    vectors++;
    if (outs() !== {4'b1011, 8'hCC}) begin
      $display("[TB] FAIL idle_word_cc: got %h expected %h", outs(), {4'b1011, 8'hCC});
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    send_range(8'h00, 7, 3);
    reset = 1'b0;
    send_bit(1'b0);
    reset = 1'b1;
    vectors++;
    if (outs() !== 12'h000) begin
      $display("[TB] FAIL midreset_clear: got %h expected %h", outs(), 12'h000);
      miscompares++;
    end
    send_range(8'h00, 1, 0);
    for (int k = 0; k < 3; k++) begin
      send_word(8'hBC);
      vectors++;
      if (outs() !== 12'h000) begin
        $display("[TB] FAIL midreset_bc%0d: got %h expected %h", k, outs(), 12'h000);
        miscompares++;
      end
    end
    send_word(8'hBC);
    vectors++;
    if (outs() !== {4'b1101, 8'h00}) begin
      $display("[TB] FAIL midreset_relock: got %h expected %h", outs(), {4'b1101, 8'h00});
      miscompares++;
    end
  endtask

  task automatic test_relock();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      send_word(words[k]);
      vectors++;
      if (outs() !== {4'b1011, words[k]}) begin
        $display("[TB] FAIL gap_word%0d: got %h expected %h", k, outs(), {4'b1011, words[k]});
        miscompares++;
      end
    end
    send_bit(1'b0);
`ifdef SP_RELOCK_EN
    vectors++;
    if (outs() !== {4'b0000, 8'h44}) begin
      $display("[TB] FAIL gap_drop: got %h expected %h", outs(), {4'b0000, 8'h44});
      miscompares++;
    end
`else
    vectors++;
    if (outs() !== {4'b1010, 8'h44}) begin
      $display("[TB] FAIL gap_hold: got %h expected %h", outs(), {4'b1010, 8'h44});
      miscompares++;
    end
    send_range(8'h00, 6, 0);
    vectors++;
    if (outs() !== {4'b1011, 8'h00}) begin
      $display("[TB] FAIL gap_word00: got %h expected %h", outs(), {4'b1011, 8'h00});
      miscompares++;
    end
    for (int k = 0; k < 3; k++) begin
      send_word(8'h5A);
      vectors++;
      if (outs() !== {4'b1011, 8'h5A}) begin
        $display("[TB] FAIL gap_stay_locked%0d: got %h expected %h", k, outs(), {4'b1011, 8'h5A});
        miscompares++;
      end
    end
`endif
  endtask

  initial begin
    bus.data_in = 1'b0;
    test_reset();
    test_lock();
    test_align_reject();
    test_idle_hold();
    test_reset_mid();
    test_relock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
